// File: rtl/step_dir_decoder_pkg.sv
// ------------------------------------------------------------------
// step_dir_decoder_pkg: shared types and defaults for the decoder.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package step_dir_decoder_pkg;

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_PEND = 2'd1,
    ST_ACC  = 2'd2
  } fsm_state_t;

  localparam int DEF_MIN_PULSE = 4;
  localparam int DEF_DIR_SETUP = 8;
  localparam int DEF_CNT_W     = 16;

endpackage

`default_nettype wire

// File: rtl/step_dir_decoder_sync_filter.sv
// ------------------------------------------------------------------
// step_sync_filter: pin synchroniser, dir stability tracking and pulse
// width qualification. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module step_sync_filter
  import step_dir_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = DEF_MIN_PULSE,
  parameter int DIR_SETUP   = DEF_DIR_SETUP
) (
  input  logic clk,
  input  logic reset,
  input  logic step_in,
  input  logic dir_in,
  output logic accept,
  output logic dir_lat,
  output logic glitch,
  output logic setup_viol
);

  localparam int HC_W = $clog2(MIN_PULSE + 1);
  localparam int ST_W = $clog2(DIR_SETUP + 1);
  localparam logic [HC_W-1:0] HC_LAST  = HC_W'(MIN_PULSE - 1);
  localparam logic [ST_W-1:0] STAB_MAX = ST_W'(DIR_SETUP);

  logic [SYNC_STAGES-1:0] step_sr;
  logic [SYNC_STAGES-1:0] dir_sr;
  logic                   s_step;
  logic                   s_dir;
  logic                   dir_prev;
  logic [ST_W-1:0]        stab;
  logic [HC_W-1:0]        hcnt;
  fsm_state_t             state;

  always_ff @(posedge clk) begin
    if (reset) begin
      step_sr <= '0;
      dir_sr  <= '0;
    end else begin
      step_sr <= {step_sr[SYNC_STAGES-2:0], step_in};
      dir_sr  <= {dir_sr[SYNC_STAGES-2:0], dir_in};
    end
  end

  assign s_step = step_sr[SYNC_STAGES-1];
  assign s_dir  = dir_sr[SYNC_STAGES-1];

  // Restarts on any dir edge, saturates once dir is considered settled.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_prev <= 1'b0;
      stab     <= STAB_MAX;
    end else begin
      dir_prev <= s_dir;
      if (s_dir != dir_prev) begin
        stab <= '0;
      end else if (stab != STAB_MAX) begin
        stab <= stab + ST_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_LOW;
      hcnt    <= '0;
      dir_lat <= 1'b0;
    end else begin
      case (state)
        ST_LOW: begin
          if (s_step) begin
            state   <= ST_PEND;
            hcnt    <= HC_W'(1);
            dir_lat <= s_dir;
          end
        end
        ST_PEND: begin
          if (!s_step) begin
            state <= ST_LOW;
          end else if (hcnt == HC_LAST) begin
            state <= ST_ACC;
          end else begin
            hcnt <= hcnt + HC_W'(1);
          end
        end
        ST_ACC: begin
          if (!s_step) begin
            state <= ST_LOW;
          end
        end
        default: state <= ST_LOW;
      endcase
    end
  end

  assign accept     = (state == ST_PEND) && s_step && (hcnt == HC_LAST);
  assign glitch     = (state == ST_PEND) && !s_step;
  assign setup_viol = (state == ST_LOW) && s_step && (stab < STAB_MAX);

endmodule

`default_nettype wire

// File: rtl/step_dir_decoder.sv
// ------------------------------------------------------------------
// step_dir_decoder: step/dir receiver producing absolute position and
// per-period step counts. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module step_dir_decoder
  import step_dir_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = DEF_MIN_PULSE,
  parameter int DIR_SETUP   = DEF_DIR_SETUP,
  parameter int POS_W       = 32,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step_in,
  input  logic                    dir_in,
  input  logic                    acc_step,
  input  logic                    load,
  input  logic signed [POS_W-1:0] pos_val,
  input  logic                    clear_err,
  output logic signed [POS_W-1:0] position,
  output logic signed [CNT_W-1:0] period_steps,
  output logic                    period_valid,
  output logic                    step_pulse,
  output logic                    dir_out,
  output logic                    moving,
  output logic                    err_glitch,
  output logic                    err_setup,
  output logic                    err_ovf
);

  localparam logic signed [CNT_W-1:0] ACC_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] ACC_MIN = -ACC_MAX;

  logic                    accept;
  logic                    dir_lat;
  logic                    glitch;
  logic                    setup_viol;
  logic signed [CNT_W-1:0] acc;
  logic signed [CNT_W-1:0] acc_next;
  logic                    sat;

  step_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .MIN_PULSE   (MIN_PULSE),
    .DIR_SETUP   (DIR_SETUP)
  ) u_filter (
    .clk        (clk),
    .reset      (reset),
    .step_in    (step_in),
    .dir_in     (dir_in),
    .accept     (accept),
    .dir_lat    (dir_lat),
    .glitch     (glitch),
    .setup_viol (setup_viol)
  );

  // Symmetric clamp: the most negative code is never produced.
  always_comb begin
    acc_next = acc;
    sat      = 1'b0;
    if (accept) begin
      if (dir_lat) begin
        if (acc == ACC_MAX) sat = 1'b1;
        else                acc_next = acc + CNT_W'(1);
      end else begin
        if (acc == ACC_MIN) sat = 1'b1;
        else                acc_next = acc - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      position     <= '0;
      period_steps <= '0;
      period_valid <= 1'b0;
      step_pulse   <= 1'b0;
      dir_out      <= 1'b0;
      moving       <= 1'b0;
      err_glitch   <= 1'b0;
      err_setup    <= 1'b0;
      err_ovf      <= 1'b0;
      acc          <= '0;
    end else begin
      step_pulse <= accept;
      if (accept) dir_out <= dir_lat;

      if (load) begin
        position <= pos_val;
      end else if (accept) begin
        position <= dir_lat ? position + POS_W'(1) : position - POS_W'(1);
      end

      period_valid <= acc_step;
      if (acc_step) begin
        period_steps <= acc_next;
        moving       <= (acc_next != '0);
        acc          <= '0;
      end else begin
        acc <= acc_next;
      end

      err_glitch <= glitch     | (err_glitch & ~clear_err);
      err_setup  <= setup_viol | (err_setup  & ~clear_err);
      err_ovf    <= sat        | (err_ovf    & ~clear_err);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_step_dir_decoder.sv
// ------------------------------------------------------------------
// tb_step_dir_decoder: directed stimulus against a run-length model of
// the step/dir receiver, two instances (wide and 4-bit period count).
// ------------------------------------------------------------------
`default_nettype none

module tb_step_dir_decoder;

  localparam int SYNC  = 2;
  localparam int MINP  = 4;
  localparam int DS    = 8;
  localparam int LIM_A = 32767;
  localparam int LIM_B = 7;

  logic clk = 1'b0;
  logic reset, step_in, dir_in, acc_step, load, clear_err;
  logic signed [31:0] pos_val;

  logic signed [31:0] pos_a, pos_b;
  logic signed [15:0] ps_a;
  logic signed [3:0]  ps_b;
  logic pv_a, sp_a, do_a, mv_a, eg_a, es_a, eo_a;
  logic pv_b, sp_b, do_b, mv_b, eg_b, es_b, eo_b;

  step_dir_decoder u_dut_a (
    .clk(clk), .reset(reset), .step_in(step_in), .dir_in(dir_in),
    .acc_step(acc_step), .load(load), .pos_val(pos_val), .clear_err(clear_err),
    .position(pos_a), .period_steps(ps_a), .period_valid(pv_a),
    .step_pulse(sp_a), .dir_out(do_a), .moving(mv_a),
    .err_glitch(eg_a), .err_setup(es_a), .err_ovf(eo_a)
  );

  step_dir_decoder #(.CNT_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .step_in(step_in), .dir_in(dir_in),
    .acc_step(acc_step), .load(load), .pos_val(pos_val), .clear_err(clear_err),
    .position(pos_b), .period_steps(ps_b), .period_valid(pv_b),
    .step_pulse(sp_b), .dir_out(do_b), .moving(mv_b),
    .err_glitch(eg_b), .err_setup(es_b), .err_ovf(eo_b)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n_edge = 0;
  int last_rise = 0;
  int npulse = 0;
  bit model_on = 1'b0;

  // Model state: pin delay queues, high run length, last dir change edge.
  bit q_step[$];
  bit q_dir[$];
  int run, last_chg, acc_a, acc_b, m_ps_a, m_ps_b;
  bit prev_dir, m_dirlat, m_pv, m_sp, m_do, m_mv_a, m_mv_b;
  bit m_eg, m_es, m_eo_a, m_eo_b;
  logic signed [31:0] m_pos;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, n_edge, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit s_step, s_dir, acc, glitch, viol, oa, ob;
    int delta, sa, sb;
    n_edge++;
    if (reset) begin
      model_on = 1'b1;
      q_step.delete();
      q_dir.delete();
      run = 0; last_chg = -1000; prev_dir = 1'b0; m_dirlat = 1'b0;
      m_pos = '0; acc_a = 0; acc_b = 0; m_ps_a = 0; m_ps_b = 0;
      m_pv = 0; m_sp = 0; m_do = 0; m_mv_a = 0; m_mv_b = 0;
      m_eg = 0; m_es = 0; m_eo_a = 0; m_eo_b = 0;
    end else begin
      q_step.push_back(step_in);
      q_dir.push_back(dir_in);
      s_step = 1'b0;
      s_dir  = 1'b0;
      if (q_step.size() > SYNC) begin
        s_step = q_step.pop_front();
        s_dir  = q_dir.pop_front();
      end
      acc = 0; glitch = 0; viol = 0;
      if (s_step) begin
        run++;
        if (run == 1) begin
          m_dirlat = s_dir;
          viol = (n_edge - last_chg) <= DS;
        end
        if (run == MINP) acc = 1;
      end else begin
        if (run > 0 && run < MINP) glitch = 1;
        run = 0;
      end
      if (s_dir != prev_dir) last_chg = n_edge;
      prev_dir = s_dir;

      delta = acc ? (m_dirlat ? 1 : -1) : 0;
      m_sp = acc;
      if (acc) m_do = m_dirlat;
      if (load) m_pos = pos_val;
      else      m_pos = m_pos + delta;

      sa = acc_a + delta; oa = 0;
      if (sa > LIM_A) begin sa = LIM_A; oa = 1; end
      else if (sa < -LIM_A) begin sa = -LIM_A; oa = 1; end
      sb = acc_b + delta; ob = 0;
      if (sb > LIM_B) begin sb = LIM_B; ob = 1; end
      else if (sb < -LIM_B) begin sb = -LIM_B; ob = 1; end

      m_pv = acc_step;
      if (acc_step) begin
        m_ps_a = sa; m_mv_a = (sa != 0); acc_a = 0;
        m_ps_b = sb; m_mv_b = (sb != 0); acc_b = 0;
      end else begin
        acc_a = sa; acc_b = sb;
      end
      m_eg   = glitch | (m_eg & !clear_err);
      m_es   = viol   | (m_es & !clear_err);
      m_eo_a = oa     | (m_eo_a & !clear_err);
      m_eo_b = ob     | (m_eo_b & !clear_err);
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("position_a", pos_a, m_pos);
      chk("position_b", pos_b, m_pos);
      chk("period_steps_a", ps_a, m_ps_a);
      chk("period_steps_b", ps_b, m_ps_b);
      chk("period_valid_a", pv_a, m_pv);
      chk("period_valid_b", pv_b, m_pv);
      chk("step_pulse_a", sp_a, m_sp);
      chk("step_pulse_b", sp_b, m_sp);
      chk("dir_out_a", do_a, m_do);
      chk("dir_out_b", do_b, m_do);
      chk("moving_a", mv_a, m_mv_a);
      chk("moving_b", mv_b, m_mv_b);
      chk("err_glitch_a", eg_a, m_eg);
      chk("err_glitch_b", eg_b, m_eg);
      chk("err_setup_a", es_a, m_es);
      chk("err_setup_b", es_b, m_es);
      chk("err_ovf_a", eo_a, m_eo_a);
      chk("err_ovf_b", eo_b, m_eo_b);
      if (sp_a) begin
        npulse++;
        chk("latency", n_edge - last_rise, SYNC + MINP);
      end
    end
  end

  task automatic tick(input int k = 1);
    repeat (k) @(negedge clk);
  endtask

  // co: 0 none, 1 acc_step on the accept edge, 2 load on the accept edge.
  task automatic pulse(input int hi, input int lo, input int co = 0);
    step_in   = 1'b1;
    last_rise = n_edge;
    for (int i = 1; i <= hi + lo; i++) begin
      @(negedge clk);
      acc_step = (co == 1 && i == 5);
      load     = (co == 2 && i == 5);
      if (i == hi) step_in = 1'b0;
    end
  endtask

  task automatic strobe_acc();
    acc_step = 1'b1;
    tick();
    acc_step = 1'b0;
  endtask

  initial begin
    reset = 1'b1; step_in = 1'b0; dir_in = 1'b1; acc_step = 1'b0;
    load = 1'b0; clear_err = 1'b0; pos_val = '0;
    tick(3);
    reset = 1'b0;
    chk("reset_position", pos_a, 0);
    chk("reset_errors", {eg_a, es_a, eo_a, eo_b}, 0);
    chk("reset_period", ps_a, 0);
    tick(12);

    repeat (10) pulse(6, 6);
    chk("fwd10_position", pos_a, 10);
    chk("fwd10_pulses", npulse, 10);
    chk("fwd10_no_setup_err", es_a, 0);

    pos_val = 100; load = 1'b1; tick(); load = 1'b0;
    dir_in = 1'b0; tick(12);
    repeat (3) pulse(6, 6);
    chk("rev3_position", pos_a, 97);
    chk("rev3_dir_out", do_a, 0);

    pulse(3, 9);
    chk("glitch_position", pos_a, 97);
    chk("glitch_pulses", npulse, 13);
    chk("glitch_err", eg_a, 1);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    chk("glitch_cleared", eg_a, 0);

    dir_in = 1'b1; tick(3);
    pulse(6, 6);
    chk("setup_err", es_a, 1);
    chk("setup_position", pos_a, 98);
    chk("setup_dir_out", do_a, 1);

    clear_err = 1'b1; strobe_acc(); clear_err = 1'b0;
    tick(2);
    repeat (5) pulse(6, 6);
    dir_in = 1'b0; tick(12);
    repeat (2) pulse(6, 6);
    strobe_acc();
    chk("period_valid_on", pv_a, 1);
    chk("period_net3", ps_a, 3);
    chk("moving_on", mv_a, 1);
    tick();
    chk("period_valid_off", pv_a, 0);
    tick(4);
    strobe_acc();
    chk("period_empty", ps_a, 0);
    chk("moving_off", mv_a, 0);

    dir_in = 1'b1; tick(12);
    pulse(6, 6, 1);
    chk("coinc_acc_period", ps_a, 1);
    chk("coinc_acc_position", pos_a, 102);
    pos_val = 500;
    pulse(6, 6, 2);
    chk("coinc_load_position", pos_a, 500);
    strobe_acc();
    chk("coinc_load_period", ps_a, 1);

    clear_err = 1'b1; strobe_acc(); clear_err = 1'b0;
    repeat (9) pulse(6, 6);
    strobe_acc();
    chk("sat_period_b", ps_b, 7);
    chk("sat_ovf_b", eo_b, 1);
    chk("sat_period_a", ps_a, 9);
    chk("sat_ovf_a", eo_a, 0);
    chk("sat_position", pos_a, 509);

    step_in = 1'b1; tick(2);
    reset = 1'b1; tick(); reset = 1'b0;
    last_rise = n_edge;
    chk("midreset_position", pos_a, 0);
    tick(8); step_in = 1'b0; tick(6);
    chk("midreset_counted", pos_a, 1);
    chk("midreset_no_setup", es_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
